// File: rtl/conv_group_sched.sv
// Group sequencer for the P-lane convolution datapath: address generation, MAC control, write strobes.
// Optional CONV_SCHED_PERF_EN adds stall_cycles / groups_done performance counters.
module conv_group_sched #(
    parameter int ADDRX   = 5,
    parameter int ADDRF   = 4,
    parameter int LENX    = 24,
    parameter int LENF    = 10,
    parameter int P       = 5,
    parameter int MEM_LAT = 1,
    parameter int MAC_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 x_loaded,
    input  logic                 out_free,
    output logic [P*ADDRX-1:0]   addr_x,
    output logic [ADDRF-1:0]     addr_f,
    output logic                 clr_acc,
    output logic                 en_acc,
    output logic                 valid_op,
    output logic [ADDRX-1:0]     start_addr,
    output logic [P-1:0]         lane_mask,
    output logic                 all_done
`ifdef CONV_SCHED_PERF_EN
    ,
    output logic [31:0]          stall_cycles,
    output logic [15:0]          groups_done
`endif
);

    localparam int SIZE = LENX - LENF + 1;
    localparam int NGRP = (SIZE + P - 1) / P;
    localparam int D    = MEM_LAT + MAC_LAT;
    localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int DW   = $clog2(D + 1);
    localparam int AW   = ADDRX + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_RUN,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [GW-1:0]        g_q, g_d;
    logic [ADDRF-1:0]     k_q, k_d;
    logic [DW-1:0]        dcnt_q, dcnt_d;
    logic [MEM_LAT-1:0]   en_sr_q;
    logic [AW-1:0]        base;
    logic [AW-1:0]        sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            g_q     <= '0;
            k_q     <= '0;
            dcnt_q  <= '0;
            en_sr_q <= '0;
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            k_q        <= k_d;
            dcnt_q     <= dcnt_d;
            // en_acc follows the RUN issue cycles by the memory read latency
            en_sr_q[0] <= (state_q == S_RUN);
            for (int i = 1; i < MEM_LAT; i++) begin
                en_sr_q[i] <= en_sr_q[i-1];
            end
        end
    end

    assign en_acc = en_sr_q[MEM_LAT-1];

    always_comb begin
        state_d    = state_q;
        g_d        = g_q;
        k_d        = k_q;
        dcnt_d     = dcnt_q;
        addr_x     = '0;
        addr_f     = '0;
        clr_acc    = 1'b0;
        valid_op   = 1'b0;
        start_addr = '0;
        lane_mask  = '0;
        all_done   = 1'b0;
        base       = AW'(g_q) * AW'(P);
        sum        = '0;

        case (state_q)
            S_IDLE: begin
                if (x_loaded) begin
                    state_d = S_CHECK;
                    g_d     = '0;
                end
            end
            S_CHECK: begin
                if (out_free) begin
                    state_d = S_RUN;
                    k_d     = '0;
                end
            end
            S_RUN: begin
                addr_f  = k_q;
                clr_acc = (k_q == '0);
                // Lanes near the end of the vector read past LENX-1; clamp them
                for (int j = 0; j < P; j++) begin
                    sum = base + AW'(j) + AW'(k_q);
                    if (sum > AW'(LENX - 1))
                        addr_x[j*ADDRX +: ADDRX] = ADDRX'(LENX - 1);
                    else
                        addr_x[j*ADDRX +: ADDRX] = sum[ADDRX-1:0];
                end
                if (k_q == ADDRF'(LENF - 1)) begin
                    state_d = S_DRAIN;
                    dcnt_d  = DW'(D - 1);
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (dcnt_q == '0)
                    state_d = S_WRITE;
                else
                    dcnt_d = dcnt_q - 1'b1;
            end
            S_WRITE: begin
                valid_op   = 1'b1;
                start_addr = base[ADDRX-1:0];
                for (int j = 0; j < P; j++) begin
                    lane_mask[j] = ((base + AW'(j)) < AW'(SIZE));
                end
                if (g_q == GW'(NGRP - 1)) begin
                    state_d = S_DONE;
                end else begin
                    g_d     = g_q + 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_DONE: begin
                all_done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef CONV_SCHED_PERF_EN
    logic [31:0] stall_q;
    logic [15:0] grp_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            grp_q   <= '0;
        end else if (state_q == S_IDLE && x_loaded) begin
            stall_q <= '0;
            grp_q   <= '0;
        end else begin
            if (state_q == S_CHECK && !out_free && stall_q != '1)
                stall_q <= stall_q + 1'b1;
            if (state_q == S_WRITE && grp_q != '1)
                grp_q <= grp_q + 1'b1;
        end
    end

    assign stall_cycles = stall_q;
    assign groups_done  = grp_q;
`endif

endmodule

// File: tb/tb_conv_group_sched.sv
// Directed bench for conv_group_sched: default geometry, remainder geometry, stall, reset abort, back-to-back runs.
module tb_conv_group_sched;

    logic clk = 1'b0;
    logic reset, x_loaded, out_free;

    logic [24:0] addr_x;
    logic [3:0]  addr_f;
    logic        clr_acc, en_acc, valid_op, all_done;
    logic [4:0]  start_addr;
    logic [4:0]  lane_mask;
`ifdef CONV_SCHED_PERF_EN
    logic [31:0] stall_cycles;
    logic [15:0] groups_done;
`endif

    logic [11:0] addr_x2;
    logic [1:0]  addr_f2;
    logic        clr2, en2, vop2, done2;
    logic [2:0]  start2;
    logic [3:0]  mask2;

    conv_group_sched dut (
        .clk(clk), .reset(reset), .x_loaded(x_loaded), .out_free(out_free),
        .addr_x(addr_x), .addr_f(addr_f), .clr_acc(clr_acc), .en_acc(en_acc),
        .valid_op(valid_op), .start_addr(start_addr), .lane_mask(lane_mask),
        .all_done(all_done)
`ifdef CONV_SCHED_PERF_EN
        , .stall_cycles(stall_cycles), .groups_done(groups_done)
`endif
    );

    conv_group_sched #(.ADDRX(3), .ADDRF(2), .LENX(8), .LENF(3), .P(4)) dut_rem (
        .clk(clk), .reset(reset), .x_loaded(x_loaded), .out_free(out_free),
        .addr_x(addr_x2), .addr_f(addr_f2), .clr_acc(clr2), .en_acc(en2),
        .valid_op(vop2), .start_addr(start2), .lane_mask(mask2),
        .all_done(done2)
`ifdef CONV_SCHED_PERF_EN
        , .stall_cycles(), .groups_done()
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    int vop_n, done_at, en_n, en_first, en_last, clr_n, clr_at;
    int vop_at[8];
    int vop_sa[8];
    int vop_m[8];
    int exp_at[4];
    int exp_sa[4];

    initial begin
        reset = 1'b1; x_loaded = 1'b0; out_free = 1'b1;
        repeat (2) @(negedge clk);
        check_val("rst_addr_x", addr_x, 0);
        check_val("rst_ctrl", {clr_acc, en_acc, valid_op, all_done}, 0);
        check_val("rst_wr", {start_addr, lane_mask}, 0);

        // Default geometry with x_loaded held high: two back-to-back runs; remainder DUT in parallel
        x_loaded = 1'b1; reset = 1'b0; cyc = 0;
        vop_n = 0; done_at = -1; en_n = 0; en_first = -1; en_last = -1; clr_n = 0; clr_at = -1;
        check_val("c0_idle", {clr_acc, valid_op, addr_x}, 0);
        while (cyc < 62) begin
            step();
            if (valid_op) begin
                if (vop_n < 8) begin
                    vop_at[vop_n] = cyc; vop_sa[vop_n] = int'(start_addr); vop_m[vop_n] = int'(lane_mask);
                end
                vop_n++;
            end
            if (all_done && done_at < 0) done_at = cyc;
            if (cyc <= 14) begin
                if (en_acc) begin en_n++; if (en_first < 0) en_first = cyc; en_last = cyc; end
                if (clr_acc) begin clr_n++; clr_at = cyc; end
            end
            if (cyc == 1)  check_val("c1_check_idle_outs", {clr_acc, addr_f, addr_x}, 0);
            if (cyc == 12) check_val("c12_drain_outs", {addr_x, addr_f, start_addr, lane_mask}, 0);
            if (cyc == 39) begin
                check_val("g2k9_addr_x", addr_x, {5'd23, 5'd22, 5'd21, 5'd20, 5'd19});
                check_val("g2k9_addr_f", addr_f, 9);
            end
            if (cyc == 7)  check_val("rem_w0", {vop2, start2, mask2}, {1'b1, 3'd0, 4'b1111});
            if (cyc == 11) begin
                check_val("rem_g1k2_addr_x", addr_x2, {3'd7, 3'd7, 3'd7, 3'd6});
                check_val("rem_g1k2_addr_f", addr_f2, 2);
            end
            if (cyc == 14) check_val("rem_w1", {vop2, start2, mask2}, {1'b1, 3'd4, 4'b0011});
            if (cyc == 15) check_val("rem_done", done2, 1);
        end
        exp_at = '{14, 28, 42, 58};
        exp_sa = '{0, 5, 10, 0};
        check_val("a_vop_count", vop_n, 4);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("a_vop%0d_cycle", i), vop_at[i], exp_at[i]);
            check_val($sformatf("a_vop%0d_start", i), vop_sa[i], exp_sa[i]);
            check_val($sformatf("a_vop%0d_mask", i), vop_m[i], 5'b11111);
        end
        check_val("a_done_cycle", done_at, 43);
        check_val("a_en_first", en_first, 3);
        check_val("a_en_last", en_last, 12);
        check_val("a_en_count", en_n, 10);
        check_val("a_clr_count", clr_n, 1);
        check_val("a_clr_cycle", clr_at, 2);

        // out_free low for 7 CHECK cycles before group 1
        x_loaded = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; x_loaded = 1'b1; cyc = 0; vop_n = 0; done_at = -1;
        while (cyc < 56) begin
            step();
            if (cyc == 1) x_loaded = 1'b0;
            out_free = !(cyc >= 15 && cyc <= 21);
            if (valid_op) begin
                if (vop_n < 8) vop_at[vop_n] = cyc;
                vop_n++;
            end
            if (cyc == 18) check_val("b_stall_quiet", {valid_op, clr_acc, en_acc, addr_x}, 0);
            if (all_done && done_at < 0) begin
                done_at = cyc;
`ifdef CONV_SCHED_PERF_EN
                check_val("b_stall_cycles", stall_cycles, 7);
                check_val("b_groups_done", groups_done, 3);
`endif
            end
        end
        exp_at = '{14, 35, 49, 0};
        check_val("b_vop_count", vop_n, 3);
        for (int i = 0; i < 3; i++) check_val($sformatf("b_vop%0d_cycle", i), vop_at[i], exp_at[i]);
        check_val("b_done_cycle", done_at, 50);

        // Reset mid-RUN aborts the group; restart after release
        out_free = 1'b1; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; x_loaded = 1'b1; cyc = 0;
        while (cyc < 8) step();
        #2 reset = 1'b1;
        #1 check_val("c_async_outs", {addr_x, addr_f, clr_acc, en_acc, valid_op, start_addr, lane_mask, all_done}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val($sformatf("c_held_%0d", i), {valid_op, all_done, en_acc}, 0);
        end
        reset = 1'b0; cyc = 0; vop_n = 0; done_at = -1; vop_at[0] = -1;
        while (cyc < 20) begin
            step();
            if (valid_op && vop_n == 0) vop_at[0] = cyc;
            if (valid_op) vop_n++;
            if (all_done && done_at < 0) done_at = cyc;
        end
        check_val("c_first_vop", vop_at[0], 14);
        check_val("c_no_early_done", done_at, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
